// File: rtl/md_pairwise_force_engine_if.sv
// Position/force streaming bundle for the pairwise force engine.
// master drives positions and force_ready; slave is the engine.
interface md_pairwise_force_engine_if #(
  parameter int COORD_W = 16,
  parameter int FORCE_W = 16,
  parameter int CW      = 7
);
  logic                 pos_valid;
  logic                 pos_ready;
  logic [3*COORD_W-1:0] pos_data;
  logic                 force_valid;
  logic                 force_ready;
  logic [3*FORCE_W-1:0] force_data;
  logic [CW-1:0]        force_idx;
  logic                 force_last;

  modport master (
    output pos_valid, pos_data, force_ready,
    input  pos_ready, force_valid, force_data,
    input  force_idx, force_last
  );

  modport slave (
    input  pos_valid, pos_data, force_ready,
    output pos_ready, force_valid, force_data,
    output force_idx, force_last
  );
endinterface

// File: rtl/md_pairwise_force_engine.sv
// All-pairs cutoff-limited linear force stage: load positions,
// sweep one pair per cycle, then stream saturated forces out.
module md_pairwise_force_engine #(
  parameter int          NUM_PARTICLES = 64,
  parameter int          COORD_W       = 16,
  parameter int          FORCE_W       = 16,
  parameter int          FORCE_SHIFT   = 4,
  parameter logic [63:0] CUTOFF_SQ     = 64'd1 << 20,
  localparam int         CW = $clog2(NUM_PARTICLES + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [CW-1:0] n_particles,
  output logic          busy,
  output logic          done,
  md_pairwise_force_engine_if.slave fif
);

  localparam int IW  = (NUM_PARTICLES > 1) ?
                       $clog2(NUM_PARTICLES) : 1;
  localparam int AW  = COORD_W + 1 + $clog2(NUM_PARTICLES);
  localparam int R2W = 2 * COORD_W + 4;
  localparam int PW  = 2 * COORD_W + 2;

  localparam logic signed [AW-1:0] FMAX =
    {{(AW-FORCE_W+1){1'b0}}, {(FORCE_W-1){1'b1}}};
  localparam logic signed [AW-1:0] FMIN =
    {{(AW-FORCE_W+1){1'b1}}, {(FORCE_W-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE, LOAD, COMPUTE, DRAIN
  } state_t;

  state_t state, state_nx;

  logic [CW-1:0] n, n_m1, n_in;
  logic [CW-1:0] k, i, j, idx;
  logic          done_q;

  logic [3*COORD_W-1:0] pos_mem   [NUM_PARTICLES];
  logic [3*FORCE_W-1:0] force_mem [NUM_PARTICLES];

  logic [3*COORD_W-1:0]        pi_w, pj_w;
  logic signed [COORD_W-1:0]   pa [3];
  logic signed [COORD_W-1:0]   pb [3];
  logic signed [COORD_W:0]     d  [3];
  logic signed [COORD_W:0]     sh [3];
  logic signed [PW-1:0]        dw [3];
  logic signed [PW-1:0]        sq [3];
  logic [R2W-1:0]              r2;
  logic                        hit;
  logic signed [AW-1:0]        acc    [3];
  logic signed [AW-1:0]        acc_nx [3];
  logic [3*FORCE_W-1:0]        fvec;

  function automatic logic [FORCE_W-1:0] sat(
    input logic signed [AW-1:0] v
  );
    if (v > FMAX)      return FMAX[FORCE_W-1:0];
    else if (v < FMIN) return FMIN[FORCE_W-1:0];
    else               return v[FORCE_W-1:0];
  endfunction

  assign n_in = (n_particles > CW'(NUM_PARTICLES)) ?
                CW'(NUM_PARTICLES) : n_particles;
  assign n_m1 = n - CW'(1);

  assign busy            = (state != IDLE);
  assign done            = done_q;
  assign fif.pos_ready   = (state == LOAD);
  assign fif.force_valid = (state == DRAIN);
  assign fif.force_last  = (state == DRAIN) && (idx == n_m1);
  assign fif.force_idx   = (state == DRAIN) ? idx : '0;
  assign fif.force_data  = (state == DRAIN) ?
                           force_mem[idx[IW-1:0]] : '0;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:
        if (start && n_in != '0) state_nx = LOAD;
      LOAD:
        if (fif.pos_valid && k == n_m1) state_nx = COMPUTE;
      COMPUTE:
        if (i == n_m1 && j == n_m1) state_nx = DRAIN;
      DRAIN:
        if (fif.force_ready && idx == n_m1) state_nx = IDLE;
    endcase
  end

  // Pair datapath: d = pos[j]-pos[i], widened so squares never wrap.
  always_comb begin
    pi_w = pos_mem[i[IW-1:0]];
    pj_w = pos_mem[j[IW-1:0]];
    r2   = '0;
    fvec = '0;
    for (int a = 0; a < 3; a++) begin
      pa[a] = pi_w[a*COORD_W +: COORD_W];
      pb[a] = pj_w[a*COORD_W +: COORD_W];
      d[a]  = (COORD_W+1)'(pb[a]) - (COORD_W+1)'(pa[a]);
      sh[a] = d[a] >>> FORCE_SHIFT;
      dw[a] = PW'(d[a]);
      sq[a] = dw[a] * dw[a];
      r2    = r2 + R2W'($unsigned(sq[a]));
    end
    hit = (i != j) && (64'(r2) < CUTOFF_SQ);
    for (int a = 0; a < 3; a++) begin
      acc_nx[a] = hit ? acc[a] + AW'(sh[a]) : acc[a];
      fvec[a*FORCE_W +: FORCE_W] = sat(acc_nx[a]);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      n      <= '0;
      k      <= '0;
      i      <= '0;
      j      <= '0;
      idx    <= '0;
      done_q <= 1'b0;
      for (int a = 0; a < 3; a++) acc[a] <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state)
        IDLE: if (start) begin
          n      <= n_in;
          k      <= '0;
          i      <= '0;
          j      <= '0;
          idx    <= '0;
          done_q <= (n_in == '0);
          for (int a = 0; a < 3; a++) acc[a] <= '0;
        end
        LOAD: if (fif.pos_valid) k <= k + CW'(1);
        COMPUTE: begin
          if (j == n_m1) begin
            j <= '0;
            i <= i + CW'(1);
            for (int a = 0; a < 3; a++) acc[a] <= '0;
          end else begin
            j <= j + CW'(1);
            for (int a = 0; a < 3; a++) acc[a] <= acc_nx[a];
          end
        end
        DRAIN: if (fif.force_ready) begin
          if (idx == n_m1) begin
            idx    <= '0;
            done_q <= 1'b1;
          end else begin
            idx <= idx + CW'(1);
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (state == LOAD && fif.pos_valid)
      pos_mem[k[IW-1:0]] <= fif.pos_data;
    if (state == COMPUTE && j == n_m1)
      force_mem[i[IW-1:0]] <= fvec;
  end

endmodule

// File: tb/tb_md_pairwise_force_engine.sv
// Three lockstep engines (default, tight cutoff, 8-bit forces)
// checked against an all-pairs integer model.
module tb_md_pairwise_force_engine;
  localparam int NP = 64;
  localparam int CW = 7;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic [CW-1:0] n_particles = '0;
  logic busy0, busy1, busy2;
  logic done0, done1, done2;

  md_pairwise_force_engine_if #(16, 16, CW) if0 ();
  md_pairwise_force_engine_if #(16, 16, CW) if1 ();
  md_pairwise_force_engine_if #(16, 8,  CW) if2 ();

  assign if1.pos_valid   = if0.pos_valid;
  assign if1.pos_data    = if0.pos_data;
  assign if1.force_ready = if0.force_ready;
  assign if2.pos_valid   = if0.pos_valid;
  assign if2.pos_data    = if0.pos_data;
  assign if2.force_ready = if0.force_ready;

  md_pairwise_force_engine u_main (
    .clk(clk), .reset(reset), .start(start),
    .n_particles(n_particles),
    .busy(busy0), .done(done0), .fif(if0.slave)
  );

  md_pairwise_force_engine #(.CUTOFF_SQ(64'd25600)) u_cut (
    .clk(clk), .reset(reset), .start(start),
    .n_particles(n_particles),
    .busy(busy1), .done(done1), .fif(if1.slave)
  );

  md_pairwise_force_engine #(
    .FORCE_W(8), .CUTOFF_SQ(64'd1 << 26)
  ) u_sat (
    .clk(clk), .reset(reset), .start(start),
    .n_particles(n_particles),
    .busy(busy2), .done(done2), .fif(if2.slave)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int px [NP];
  int py [NP];
  int pz [NP];
  int ef [3][NP][3];
  longint cuts [3] = '{64'd1 << 20, 64'd25600, 64'd1 << 26};
  int fws [3] = '{16, 16, 8};
  int cur_n = 0;
  int exp_idx = 0;
  int done_cnt = 0;
  bit fv_allowed = 0;
  bit done_pending = 0;

  task automatic chk(input string nm, input longint act,
                     input longint req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, req);
    end
  endtask

  function automatic int satf(input int v, input int fw);
    int mx, mn;
    mx = (1 << (fw - 1)) - 1;
    mn = -(1 << (fw - 1));
    if (v > mx) return mx;
    if (v < mn) return mn;
    return v;
  endfunction

  task automatic build_model(input int n);
    for (int d = 0; d < 3; d++) begin
      for (int i = 0; i < n; i++) begin
        int s0, s1, s2;
        s0 = 0; s1 = 0; s2 = 0;
        for (int j = 0; j < n; j++) begin
          int dx, dy, dz;
          longint r2;
          dx = px[j] - px[i];
          dy = py[j] - py[i];
          dz = pz[j] - pz[i];
          r2 = longint'(dx) * dx + longint'(dy) * dy
             + longint'(dz) * dz;
          if (j != i && r2 < cuts[d]) begin
            s0 += dx >>> 4;
            s1 += dy >>> 4;
            s2 += dz >>> 4;
          end
        end
        ef[d][i][0] = satf(s0, fws[d]);
        ef[d][i][1] = satf(s1, fws[d]);
        ef[d][i][2] = satf(s2, fws[d]);
      end
    end
  endtask

  task automatic rand_pos(input int n, input int r);
    for (int k = 0; k < n; k++) begin
      px[k] = int'($urandom_range(0, 2 * r)) - r;
      py[k] = int'($urandom_range(0, 2 * r)) - r;
      pz[k] = int'($urandom_range(0, 2 * r)) - r;
    end
  endtask

  // Per-cycle output checker
  logic [47:0] prev_fd;
  int prev_idx = 0;
  bit stall = 0;

  always @(negedge clk) begin
    bit newp;
    int a0, a1, a2;
    if (reset) begin
      stall = 0;
      done_pending = 0;
    end else begin
      newp = 0;
      if (done_pending || done0 || done1 || done2) begin
        chk("done_main", done0, done_pending);
        chk("done_cut",  done1, done_pending);
        chk("done_sat",  done2, done_pending);
      end
      if (done0) done_cnt++;
      if (!fv_allowed)
        chk("no_valid",
            if0.force_valid | if1.force_valid | if2.force_valid, 0);
      else if (if0.force_valid) begin
        chk("lock_cut", if1.force_valid, 1);
        chk("lock_sat", if2.force_valid, 1);
        chk("idx", if0.force_idx, exp_idx);
        chk("last", if0.force_last, exp_idx == cur_n - 1);
        if (stall) begin
          chk("stall_data", if0.force_data, prev_fd);
          chk("stall_idx", if0.force_idx, prev_idx);
        end
        if (exp_idx < NP) begin
          for (int a = 0; a < 3; a++) begin
            a0 = int'($signed(if0.force_data[a*16 +: 16]));
            a1 = int'($signed(if1.force_data[a*16 +: 16]));
            a2 = int'($signed(if2.force_data[a*8 +: 8]));
            chk($sformatf("f_main[%0d][%0d]", exp_idx, a),
                a0, ef[0][exp_idx][a]);
            chk($sformatf("f_cut[%0d][%0d]", exp_idx, a),
                a1, ef[1][exp_idx][a]);
            chk($sformatf("f_sat[%0d][%0d]", exp_idx, a),
                a2, ef[2][exp_idx][a]);
          end
        end
        if (if0.force_ready) begin
          if (exp_idx == cur_n - 1) newp = 1;
          exp_idx++;
        end
      end
      if (start && !busy0 && n_particles == '0) newp = 1;
      stall = if0.force_valid && !if0.force_ready;
      prev_fd = if0.force_data;
      prev_idx = int'(if0.force_idx);
      done_pending = newp;
    end
  end

  task automatic run(input int n_req, input bit gaps,
                     input bit slow, input bit poke,
                     input bit abort);
    int n, k, c, got;
    n = (n_req > NP) ? NP : n_req;
    cur_n = n;
    build_model(n);
    exp_idx = 0;
    done_cnt = 0;
    @(posedge clk); #1;
    start = 1'b1;
    n_particles = CW'(n_req);
    @(posedge clk); #1;
    start = poke;
    n_particles = '0;
    if (n == 0) begin
      repeat (3) @(posedge clk);
      #1;
      chk("done_once_n0", done_cnt, 1);
      chk("idle_n0", busy0, 0);
      return;
    end
    k = 0;
    c = 0;
    while (k < n && c < 5000) begin
      if0.pos_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      if0.pos_data = {16'(pz[k]), 16'(py[k]), 16'(px[k])};
      @(negedge clk);
      got = int'(if0.pos_valid && if0.pos_ready);
      @(posedge clk); #1;
      k += got;
      c++;
    end
    chk("load_beats", k, n);
    if0.pos_valid = 1'b0;
    start = 1'b0;
    chk("pos_ready_off", if0.pos_ready, 0);
    if (abort) begin
      repeat (5) @(posedge clk);
      #1 reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      chk("abort_busy", busy0, 0);
      chk("abort_valid", if0.force_valid, 0);
      chk("abort_ready", if0.pos_ready, 0);
      chk("abort_done", done0, 0);
      repeat (n * n + 5) @(posedge clk);
      #1;
      chk("abort_no_done", done_cnt, 0);
      return;
    end
    fv_allowed = 1;
    c = 0;
    while (c < n * n + 10) begin
      @(negedge clk);
      if (if0.force_valid) break;
      @(posedge clk); #1;
      c++;
    end
    chk("latency", c, n * n);
    @(posedge clk); #1;
    got = 0;
    c = 0;
    while (got < n && c < 5000) begin
      if0.force_ready = slow ?
        ($urandom_range(0, 2) == 0) : 1'b1;
      @(negedge clk);
      if (if0.force_valid && if0.force_ready) got++;
      @(posedge clk); #1;
      c++;
    end
    chk("drain_beats", got, n);
    if0.force_ready = 1'b0;
    fv_allowed = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("done_once", done_cnt, 1);
    chk("idle_after", busy0, 0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    if0.pos_valid = 1'b0;
    if0.pos_data = '0;
    if0.force_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy0, 0);
    chk("rst_done", done0, 0);
    chk("rst_pos_ready", if0.pos_ready, 0);
    chk("rst_valid", if0.force_valid, 0);
    chk("rst_last", if0.force_last, 0);
    chk("rst_data", if0.force_data, 0);
    chk("rst_idx", if0.force_idx, 0);
    reset = 1'b0;

    px[0] = 0;   py[0] = 0; pz[0] = 0;
    px[1] = 160; py[1] = 0; pz[1] = 0;
    build_model(2);
    chk("pin_f0x", ef[0][0][0], 10);
    chk("pin_f1x", ef[0][1][0], -10);
    chk("pin_cut_f0x", ef[1][0][0], 0);
    run(2, 0, 0, 0, 0);

    px[1] = 4000;
    build_model(2);
    chk("pin_sat_f0x", ef[2][0][0], 127);
    chk("pin_sat_f1x", ef[2][1][0], -128);
    chk("pin_far_f0x", ef[0][0][0], 0);
    run(2, 0, 1, 0, 0);

    for (int t = 0; t < 3; t++) begin
      rand_pos(4, 700);
      run(4, 1, 1, 0, 0);
    end
    rand_pos(1, 500);
    run(1, 0, 0, 0, 0);
    rand_pos(12, 2000);
    run(12, 1, 1, 0, 0);

    run(0, 0, 0, 0, 0);
    rand_pos(3, 600);
    run(3, 0, 1, 1, 0);
    rand_pos(NP, 1500);
    run(NP + 5, 0, 0, 0, 0);

    rand_pos(4, 700);
    run(4, 0, 0, 0, 1);
    rand_pos(4, 700);
    run(4, 1, 1, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
